// File: rtl/stream_checker.sv
// AXI4-Stream sink: per-frame masked sum, beat count and optional sequence-error count.
// Optional sequence checker enabled by defining STREAM_CHECKER_SEQ_CHECK_EN.
module stream_checker #(
    parameter int unsigned DATA_SIZE = 32,
    parameter int unsigned SUM_SIZE  = 48
) (
    input  logic                   s00_axis_aclk,
    input  logic                   s00_axis_aresetn,
    input  logic                   s00_axis_enable,
    input  logic [DATA_SIZE-1:0]   s00_axis_tdata,
    input  logic [DATA_SIZE/8-1:0] s00_axis_tstrb,
    input  logic                   s00_axis_tvalid,
    output logic                   s00_axis_tready,
    input  logic                   s00_axis_tlast,
    output logic [SUM_SIZE-1:0]    result_sum,
    output logic [15:0]            result_beats,
    output logic [15:0]            result_errors,
    output logic                   result_valid,
    input  logic                   result_ready,
    output logic [15:0]            frame_count
);

    localparam int unsigned StrbW = DATA_SIZE / 8;

    typedef enum logic [1:0] {StIdle, StAccum, StHold} state_e;

    state_e              state_q;
    logic [SUM_SIZE-1:0] sum_q;
    logic [SUM_SIZE-1:0] sum_d;
    logic [SUM_SIZE-1:0] masked;
    logic [15:0]         beats_q;
    logic [15:0]         beats_d;
    logic                xfer;
    logic                accept;

    assign s00_axis_tready = s00_axis_enable && (state_q != StHold);
    assign xfer            = s00_axis_tvalid && s00_axis_tready;
    assign accept          = result_valid && result_ready;

    always_comb begin
        masked = '0;
        for (int i = 0; i < StrbW; i++) begin
            if (s00_axis_tstrb[i]) begin
                masked[8*i +: 8] = s00_axis_tdata[8*i +: 8];
            end
        end
    end

    assign sum_d   = sum_q + masked;
    assign beats_d = (beats_q == 16'hFFFF) ? beats_q : beats_q + 16'd1;

    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            state_q      <= StIdle;
            sum_q        <= '0;
            beats_q      <= '0;
            result_sum   <= '0;
            result_beats <= '0;
            result_valid <= 1'b0;
            frame_count  <= '0;
        end else begin
            case (state_q)
                StIdle, StAccum: begin
                    if (xfer) begin
                        sum_q   <= sum_d;
                        beats_q <= beats_d;
                        if (s00_axis_tlast) begin
                            result_sum   <= sum_d;
                            result_beats <= beats_d;
                            result_valid <= 1'b1;
                            state_q      <= StHold;
                        end else begin
                            state_q <= StAccum;
                        end
                    end
                end
                StHold: begin
                    if (accept) begin
                        result_valid <= 1'b0;
                        sum_q        <= '0;
                        beats_q      <= '0;
                        frame_count  <= frame_count + 16'd1;
                        state_q      <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef STREAM_CHECKER_SEQ_CHECK_EN
    logic [DATA_SIZE-1:0] ref_q;
    logic [DATA_SIZE-1:0] ref_inc;
    logic [15:0]          errors_q;
    logic [15:0]          errors_d;
    logic                 mismatch;

    // First beat of a frame only seeds the reference.
    assign ref_inc  = ref_q + {{(DATA_SIZE-1){1'b0}}, 1'b1};
    assign mismatch = (state_q == StAccum) && (s00_axis_tdata != ref_inc);
    assign errors_d = (mismatch && errors_q != 16'hFFFF) ? errors_q + 16'd1 : errors_q;

    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            ref_q         <= '0;
            errors_q      <= '0;
            result_errors <= '0;
        end else if (xfer) begin
            ref_q    <= s00_axis_tdata;
            errors_q <= errors_d;
            if (s00_axis_tlast) begin
                result_errors <= errors_d;
            end
        end else if (accept) begin
            errors_q <= '0;
        end
    end
`else
    assign result_errors = '0;
`endif

endmodule

// File: tb/tb_stream_checker.sv
// Scoreboard bench for stream_checker: directed frames plus randomized frames against a frame model.
module tb_stream_checker;

    localparam int DW = 32;
    localparam int SW = 48;
    localparam int BW = DW / 8;
`ifdef STREAM_CHECKER_SEQ_CHECK_EN
    localparam int ExpErr = 1;
`else
    localparam int ExpErr = 0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic [DW-1:0] tdata = '0;
    logic [BW-1:0] tstrb = '0;
    logic          tvalid = 1'b0;
    logic          tlast = 1'b0;
    logic          tready;
    logic [SW-1:0] rsum;
    logic [15:0]   rbeats;
    logic [15:0]   rerr;
    logic          rvalid;
    logic          rready;
    logic [15:0]   fcount;

    logic rr_dir = 1'b1;
    logic rr_rand = 1'b1;
    bit   rand_ready = 1'b0;
    bit   rand_en = 1'b0;

    assign rready = rand_ready ? rr_rand : rr_dir;

    stream_checker #(.DATA_SIZE(DW), .SUM_SIZE(SW)) dut (
        .s00_axis_aclk   (clk),
        .s00_axis_aresetn(rst_n),
        .s00_axis_enable (enable),
        .s00_axis_tdata  (tdata),
        .s00_axis_tstrb  (tstrb),
        .s00_axis_tvalid (tvalid),
        .s00_axis_tready (tready),
        .s00_axis_tlast  (tlast),
        .result_sum      (rsum),
        .result_beats    (rbeats),
        .result_errors   (rerr),
        .result_valid    (rvalid),
        .result_ready    (rready),
        .frame_count     (fcount)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1 rr_rand = 1'($urandom_range(0, 1));
    end

    typedef struct {
        logic [SW-1:0] sum;
        logic [15:0]   beats;
        logic [15:0]   errs;
    } rec_t;

    rec_t          sb[$];
    logic [DW-1:0] fd[$];
    logic [BW-1:0] fs[$];
    logic [15:0]   exp_fc = '0;
    logic [15:0]   fc_want = '0;
    bit            fc_pending = 1'b0;
    int            total = 0;
    int            bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level reference: byte-masked sum, beat count, count of non-incrementing beats.
    function automatic rec_t model_frame();
        rec_t          r;
        logic [SW-1:0] m;
        r.sum   = '0;
        r.errs  = '0;
        r.beats = (fd.size() > 65535) ? 16'hFFFF : 16'(fd.size());
        for (int i = 0; i < fd.size(); i++) begin
            m = '0;
            for (int b = 0; b < BW; b++) begin
                if (fs[i][b]) m = m + (SW'(fd[i][8*b +: 8]) << (8 * b));
            end
            r.sum = r.sum + m;
            if (ExpErr != 0 && i > 0 && fd[i] != fd[i-1] + 32'd1 && r.errs != 16'hFFFF) begin
                r.errs = r.errs + 16'd1;
            end
        end
        return r;
    endfunction

    // Monitor: compares presented results to the scoreboard head every cycle it is valid.
    always @(negedge clk) begin
        if (rst_n) begin
            if (fc_pending) begin
                check("frame_count", 64'(fcount), 64'(fc_want));
                fc_pending = 1'b0;
            end
            check("tready_rule", 64'(tready), 64'(enable && !rvalid));
            if (rvalid) begin
                if (sb.size() == 0) begin
                    check("unexpected_result", 64'(rvalid), 64'd0);
                end else begin
                    check("result_sum", 64'(rsum), 64'(sb[0].sum));
                    check("result_beats", 64'(rbeats), 64'(sb[0].beats));
                    check("result_errors", 64'(rerr), 64'(sb[0].errs));
                    if (rready) begin
                        sb.delete(0);
                        exp_fc     = exp_fc + 16'd1;
                        fc_want    = exp_fc;
                        fc_pending = 1'b1;
                    end
                end
            end
        end
    end

    task automatic send(input logic [DW-1:0] d, input logic [BW-1:0] s, input logic l);
        bit done = 1'b0;
        tdata  = d;
        tstrb  = s;
        tlast  = l;
        tvalid = 1'b1;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clk);
            if (tready) begin
                @(posedge clk);
                #1;
                done = 1'b1;
                fd.push_back(d);
                fs.push_back(s);
                if (l) begin
                    sb.push_back(model_frame());
                    fd.delete();
                    fs.delete();
                end
            end else if (rand_en && !enable) begin
                @(posedge clk);
                #1 enable = 1'b1;
            end
        end
        if (!done) check("transfer_timeout", 64'd0, 64'd1);
        if (done && l) begin
            @(negedge clk);
            check("valid_latency", 64'(rvalid), 64'd1);
        end
    endtask

    task automatic expect_now(input logic [SW-1:0] s, input logic [15:0] b, input logic [15:0] e);
        check("direct_sum", 64'(rsum), 64'(s));
        check("direct_beats", 64'(rbeats), 64'(b));
        check("direct_errors", 64'(rerr), 64'(e));
    endtask

    task automatic drain();
        tvalid = 1'b0;
        tlast  = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (sb.size() == 0 && !fc_pending) break;
        end
        check("drain_timeout", 64'(sb.size()), 64'd0);
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        tvalid     = 1'b0;
        tlast      = 1'b0;
        sb.delete();
        fd.delete();
        fs.delete();
        exp_fc     = '0;
        fc_pending = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 64'(rvalid), 64'd0);
        check("rst_sum", 64'(rsum), 64'd0);
        check("rst_beats", 64'(rbeats), 64'd0);
        check("rst_errors", 64'(rerr), 64'd0);
        check("rst_frame_count", 64'(fcount), 64'd0);
        check("rst_tready", 64'(tready), 64'(enable));
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        enable = 1'b1;
        do_reset();

        // Basic frame 1..4
        send(32'd1, 4'hF, 1'b0);
        send(32'd2, 4'hF, 1'b0);
        send(32'd3, 4'hF, 1'b0);
        send(32'd4, 4'hF, 1'b1);
        expect_now(48'd10, 16'd4, 16'd0);
        drain();
        check("tp1_frame_count", 64'(fcount), 64'd1);

        // Sequence break 5,6,9,10
        send(32'd5, 4'hF, 1'b0);
        send(32'd6, 4'hF, 1'b0);
        send(32'd9, 4'hF, 1'b0);
        send(32'd10, 4'hF, 1'b1);
        expect_now(48'd30, 16'd4, 16'(ExpErr));
        drain();

        // Result back-pressure
        rr_dir = 1'b0;
        send(32'd20, 4'hF, 1'b0);
        send(32'd21, 4'hF, 1'b1);
        repeat (5) begin
            @(negedge clk);
            check("hold_tready", 64'(tready), 64'd0);
            check("hold_valid", 64'(rvalid), 64'd1);
            check("hold_sum", 64'(rsum), 64'd41);
        end
        @(posedge clk);
        #1 rr_dir = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("post_handshake_tready", 64'(tready), 64'd1);
        check("post_handshake_valid", 64'(rvalid), 64'd0);
        drain();

        // Single-beat masked frame
        send(32'h1122_3344, 4'b0101, 1'b1);
        expect_now(48'h0022_0044, 16'd1, 16'd0);
        drain();

        // Enable stall mid-frame
        send(32'd1, 4'hF, 1'b0);
        send(32'd2, 4'hF, 1'b0);
        enable = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("stall_tready", 64'(tready), 64'd0);
            @(posedge clk);
            #1;
        end
        enable = 1'b1;
        send(32'd3, 4'hF, 1'b0);
        send(32'd4, 4'hF, 1'b1);
        expect_now(48'd10, 16'd4, 16'd0);
        drain();

        // Reset mid-frame discards the partial frame
        send(32'd1, 4'hF, 1'b0);
        send(32'd2, 4'hF, 1'b0);
        #2;
        do_reset();
        send(32'd7, 4'hF, 1'b0);
        send(32'd8, 4'hF, 1'b1);
        expect_now(48'd15, 16'd2, 16'd0);
        drain();
        check("reset_frame_count", 64'(fcount), 64'd1);

        // Randomized frames with random strobes, enable gaps and result back-pressure
        rand_en    = 1'b1;
        rand_ready = 1'b1;
        for (int f = 0; f < 40; f++) begin
            int unsigned   len;
            logic [DW-1:0] base;
            logic [DW-1:0] d;
            len  = $urandom_range(1, 8);
            base = $urandom;
            for (int k = 0; k < len; k++) begin
                d = base + DW'(k);
                if ($urandom_range(0, 5) == 0) d = $urandom;
                enable = ($urandom_range(0, 3) != 0);
                send(d, BW'($urandom_range(0, 15)), (k == len - 1));
            end
        end
        rand_en    = 1'b0;
        enable     = 1'b1;
        rr_dir     = 1'b1;
        rand_ready = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
